// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle MIPS-subset CPU (FETCH/DECODE/EXEC/MEM/HALT)
// with req/ready instruction and data memory ports.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   imem_req/addr    fetch request and byte address (= PC)
//   imem_ready/rdata fetch completion and 32-bit instruction word
//   dmem_req/we      data request, 1 = store / 0 = load
//   dmem_addr/wdata  data byte address and store data
//   dmem_ready/rdata access completion and load data
//   halted, illegal  core stopped; stopped on an unknown opcode/funct
//   overflow         sticky signed overflow from add/sub/addi
//   instr_count      retired instructions, wraps modulo 2^32
module multicycle_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            halted,
    output logic            illegal,
    output logic            overflow,
    output logic [31:0]     instr_count
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int MSB = XLEN - 1;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] rf_q [NREGS];

    logic            imem_req_q;
    logic            dmem_req_q;
    logic            dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q;
    logic [XLEN-1:0] dmem_wdata_q;
    logic            halted_q;
    logic            illegal_q;
    logic            overflow_q;
    logic [31:0]     icount_q;

    // Instruction fields; register indices wrap modulo NREGS.
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [RW-1:0]   rs_idx;
    logic [RW-1:0]   rt_idx;
    logic [RW-1:0]   rd_idx;
    logic [XLEN-1:0] simm;

    assign op     = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs_idx = ir_q[21 +: RW];
    assign rt_idx = ir_q[16 +: RW];
    assign rd_idx = ir_q[11 +: RW];
    assign simm   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

    logic unused_fields;
    assign unused_fields = ^ir_q[25:6];

    // Shared adder: R-type uses rt, everything else the immediate.
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            add_ovf;
    logic            sub_ovf;
    logic            lt;

    assign opb     = (op == OP_R) ? b_q : imm_q;
    assign sum     = a_q + opb;
    assign diff    = a_q - b_q;
    assign add_ovf = (a_q[MSB] == opb[MSB]) && (sum[MSB] != a_q[MSB]);
    assign sub_ovf = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
    assign lt      = $signed(a_q) < $signed(b_q);

    logic            ex_legal;
    logic            ex_mem;
    logic            ex_store;
    logic            ex_halt;
    logic            ex_wr;
    logic [RW-1:0]   ex_widx;
    logic [XLEN-1:0] ex_res;
    logic            ex_ovf;
    logic [XLEN-1:0] pc_d;

    // pc_q already points past the current instruction here.
    always_comb begin
        ex_legal = 1'b1;
        ex_mem   = 1'b0;
        ex_store = 1'b0;
        ex_halt  = 1'b0;
        ex_wr    = 1'b0;
        ex_widx  = rt_idx;
        ex_res   = sum;
        ex_ovf   = 1'b0;
        pc_d     = pc_q;
        unique case (op)
            OP_R: begin
                ex_wr   = 1'b1;
                ex_widx = rd_idx;
                unique case (funct)
                    F_ADD: begin
                        ex_res = sum;
                        ex_ovf = add_ovf;
                    end
                    F_SUB: begin
                        ex_res = diff;
                        ex_ovf = sub_ovf;
                    end
                    F_AND: ex_res = a_q & b_q;
                    F_OR:  ex_res = a_q | b_q;
                    F_SLT: ex_res = {{(XLEN-1){1'b0}}, lt};
                    default: begin
                        ex_legal = 1'b0;
                        ex_wr    = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                ex_wr  = 1'b1;
                ex_ovf = add_ovf;
            end
            OP_LW: ex_mem = 1'b1;
            OP_SW: begin
                ex_mem   = 1'b1;
                ex_store = 1'b1;
            end
            OP_BEQ: begin
                if (a_q == b_q) pc_d = pc_q + (imm_q << 2);
            end
            OP_J:    pc_d = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
            OP_HALT: ex_halt = 1'b1;
            default: ex_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            pc_q         <= PC_RESET;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            overflow_q   <= 1'b0;
            icount_q     <= '0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    // First cycle after reset only raises the request.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ready) begin
                        ir_q       <= imem_rdata;
                        pc_q       <= pc_q + FOUR;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rf_q[rs_idx];
                    b_q     <= rf_q[rt_idx];
                    imm_q   <= simm;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (!ex_legal) begin
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                        state_q   <= S_HALT;
                    end else if (ex_mem) begin
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= ex_store;
                        dmem_addr_q  <= sum;
                        dmem_wdata_q <= b_q;
                        state_q      <= S_MEM;
                    end else if (ex_halt) begin
                        halted_q <= 1'b1;
                        icount_q <= icount_q + 32'd1;
                        state_q  <= S_HALT;
                    end else begin
                        if (ex_wr && ex_widx != '0) rf_q[ex_widx] <= ex_res;
                        if (ex_ovf) overflow_q <= 1'b1;
                        pc_q       <= pc_d;
                        icount_q   <= icount_q + 32'd1;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (!dmem_we_q && rt_idx != '0) rf_q[rt_idx] <= dmem_rdata;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        icount_q   <= icount_q + 32'd1;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign overflow    = overflow_q;
    assign instr_count = icount_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs against multicycle_core
// (default config plus an NREGS=8 instance), with memory models.
module tb_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        halted;
    logic        illegal;
    logic        overflow;
    logic [31:0] instr_count;

    multicycle_core dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .halted      (halted),
        .illegal     (illegal),
        .overflow    (overflow),
        .instr_count (instr_count)
    );

    logic        rst8;
    logic        i8_req;
    logic [31:0] i8_addr;
    logic        i8_ready;
    logic [31:0] i8_rdata;
    logic        d8_req;
    logic        d8_we;
    logic [31:0] d8_addr;
    logic [31:0] d8_wdata;
    logic        d8_ready;
    logic [31:0] d8_rdata;
    logic        h8;
    logic        il8;
    logic        ov8;
    logic [31:0] ic8;

    multicycle_core #(.NREGS(8)) dut8 (
        .clk         (clk),
        .rst         (rst8),
        .imem_req    (i8_req),
        .imem_addr   (i8_addr),
        .imem_ready  (i8_ready),
        .imem_rdata  (i8_rdata),
        .dmem_req    (d8_req),
        .dmem_we     (d8_we),
        .dmem_addr   (d8_addr),
        .dmem_wdata  (d8_wdata),
        .dmem_ready  (d8_ready),
        .dmem_rdata  (d8_rdata),
        .halted      (h8),
        .illegal     (il8),
        .overflow    (ov8),
        .instr_count (ic8)
    );

    // Main memories: programmable ready latency, word 4 reads as a ROM constant.
    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:15];
    int ilat = 0;
    int dlat = 0;
    int icnt = 0;
    int dcnt = 0;

    assign imem_rdata = imem[imem_addr[8:2]];
    assign imem_ready = imem_req && (icnt == ilat);
    assign dmem_ready = dmem_req && (dcnt == dlat);
    assign dmem_rdata = (dmem_addr[5:2] == 4'd4) ? 32'hDEADBEEF
                                                 : dmem[dmem_addr[5:2]];

    always @(posedge clk) begin
        if (!imem_req || imem_ready) icnt <= 0;
        else icnt <= icnt + 1;
        if (!dmem_req || dmem_ready) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 32'hA5A5A5A5;
        end else if (dmem_req && dmem_ready && dmem_we) begin
            dmem[dmem_addr[5:2]] <= dmem_wdata;
        end
    end

    // Observers: sw hold cycles, fetch address log, count at overflow rise.
    int          sw8_n = 0;
    int          fn = 0;
    int          ovf_at = 0;
    logic [31:0] flog [0:15];

    always @(negedge clk) begin
        if (!rst) begin
            sw8_n  <= 0;
            fn     <= 0;
            ovf_at <= 0;
        end else begin
            if (dmem_req && dmem_we && dmem_addr == 32'd8 &&
                dmem_wdata == 32'hDEADBEEF)
                sw8_n <= sw8_n + 1;
            if (imem_req && imem_ready && fn < 16) begin
                flog[fn[3:0]] <= imem_addr;
                fn <= fn + 1;
            end
            if (overflow && ovf_at == 0) ovf_at <= int'(instr_count);
        end
    end

    // NREGS=8 instance: zero-wait memories, store log only.
    logic [31:0] imem8 [0:7];
    logic [31:0] st8 [0:3];

    assign i8_rdata = imem8[i8_addr[4:2]];
    assign i8_ready = i8_req;
    assign d8_ready = d8_req;
    assign d8_rdata = 32'h0;

    always @(posedge clk) begin
        if (!rst8) begin
            for (int i = 0; i < 4; i++) st8[i] <= 32'hA5A5A5A5;
        end else if (d8_req && d8_we) begin
            st8[d8_addr[3:2]] <= d8_wdata;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Release reset; cyc = cycles from first fetch request to halted.
    task automatic run(input int lim, output int cyc);
        int n;
        n = 0;
        rst = 1'b1;
        while (!imem_req && n < lim) begin
            @(negedge clk);
            n++;
        end
        cyc = 0;
        while (!halted && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_bound", 64'(cyc < lim), 64'd1);
    endtask

    localparam logic [31:0] HALT = 32'hFC000000;
    logic [31:0] exp_f [0:8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100,
                                 32'h104, 32'h100, 32'h104, 32'h100};

    initial begin
        int cyc;
        int n;
        rst  = 1'b0;
        rst8 = 1'b0;
        imem8[0] = 32'h20090055;
        imem8[1] = 32'h20080007;
        imem8[2] = 32'hAC010000;
        imem8[3] = 32'hAC080004;
        imem8[4] = HALT;

        // P1: addi/addi/add/halt, ready tied high
        imem[0] = 32'h20010005;
        imem[1] = 32'h20020007;
        imem[2] = 32'h00221820;
        imem[3] = HALT;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_flags", {halted, illegal, overflow}, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_pc", imem_addr, 0);
        rst8 = 1'b1;
        run(100, cyc);
        chk("p1_cycles", cyc, 12);
        chk("p1_count", instr_count, 4);
        chk("p1_pc", imem_addr, 16);
        chk("p1_reqs", {imem_req, dmem_req}, 0);
        chk("p1_ill_ovf", {illegal, overflow}, 0);

        // P2: ALU ops stored to memory, one fetch wait state each
        rst_pulse();
        ilat = 1;
        imem[3]  = 32'h00222022;
        imem[4]  = 32'h00222824;
        imem[5]  = 32'h00223025;
        imem[6]  = 32'h0081382A;
        imem[7]  = 32'h0024402A;
        imem[8]  = 32'hAC030000;
        imem[9]  = 32'hAC040004;
        imem[10] = 32'hAC050008;
        imem[11] = 32'hAC06000C;
        imem[12] = 32'hAC070010;
        imem[13] = 32'hAC080014;
        imem[14] = HALT;
        run(300, cyc);
        chk("p2_cycles", cyc, 66);
        chk("p2_add", dmem[0], 32'd12);
        chk("p2_sub", dmem[1], 32'hFFFFFFFE);
        chk("p2_and", dmem[2], 32'd5);
        chk("p2_or", dmem[3], 32'd7);
        chk("p2_slt_t", dmem[4], 32'd1);
        chk("p2_slt_f", dmem[5], 32'd0);
        chk("p2_count", instr_count, 15);

        // P3: sw/lw with 3 data wait states
        rst_pulse();
        ilat = 0;
        dlat = 3;
        imem[0] = 32'h8C020010;
        imem[1] = 32'hAC020008;
        imem[2] = 32'h8C040008;
        imem[3] = 32'hAC04000C;
        imem[4] = HALT;
        run(300, cyc);
        chk("p3_cycles", cyc, 31);
        chk("p3_sw_hold", sw8_n, 4);
        chk("p3_sw_data", dmem[2], 32'hDEADBEEF);
        chk("p3_lw_data", dmem[3], 32'hDEADBEEF);
        chk("p3_count", instr_count, 5);

        // P4: doubling 0x7FFF until signed overflow
        rst_pulse();
        dlat = 0;
        imem[0] = 32'h20017FFF;
        for (int i = 1; i <= 17; i++) imem[i] = 32'h00210820;
        imem[18] = 32'h00001020;
        imem[19] = 32'hAC010000;
        imem[20] = HALT;
        run(300, cyc);
        chk("p4_ovf_at", ovf_at, 18);
        chk("p4_ovf_sticky", overflow, 1);
        chk("p4_wrapped", dmem[0], 32'hFFFE0000);
        chk("p4_cycles", cyc, 64);
        chk("p4_count", instr_count, 21);

        // P5: beq not taken, j, then a taken backward beq loop
        rst_pulse();
        imem[0]  = 32'h20010001;
        imem[1]  = 32'h20020002;
        imem[2]  = 32'h10220005;
        imem[3]  = 32'h08000040;
        imem[64] = 32'h20630001;
        imem[65] = 32'h1021FFFE;
        rst = 1'b1;
        n = 0;
        while (fn < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("p5_bound", 64'(n < 200), 1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("p5_fetch%0d", i), flog[i], exp_f[i]);

        // P6: unknown opcode 0x3E
        rst_pulse();
        imem[0] = 32'h20010003;
        imem[1] = 32'hF8000000;
        run(100, cyc);
        chk("p6_illegal", {illegal, halted}, 2'b11);
        chk("p6_count", instr_count, 1);
        chk("p6_pc", imem_addr, 8);
        chk("p6_cycles", cyc, 6);

        // P7: R-type with funct 0x00
        rst_pulse();
        imem[0] = 32'h00000000;
        run(100, cyc);
        chk("p7_illegal", {illegal, halted}, 2'b11);
        chk("p7_count", instr_count, 0);
        chk("p7_pc", imem_addr, 4);

        // P8: registers cleared by reset; async reset during MEM
        rst_pulse();
        dlat = 10;
        imem[0] = 32'hAC010004;
        imem[1] = 32'h8C010000;
        imem[2] = HALT;
        rst = 1'b1;
        n = 0;
        while (!(dmem_req && !dmem_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("p8_bound", 64'(n < 100), 1);
        chk("p8_reg_clear", dmem[1], 0);
        chk("p8_count_pre", instr_count, 1);
        #2 rst = 1'b0;
        #1;
        chk("p8_dreq_drop", dmem_req, 0);
        chk("p8_outs0", {imem_req, dmem_we, halted, illegal, overflow}, 0);
        chk("p8_daddr0", dmem_addr, 0);
        chk("p8_count0", instr_count, 0);
        chk("p8_pc0", imem_addr, 0);
        @(negedge clk);
        dlat = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("p8_refetch", {imem_req, imem_addr}, {1'b1, 32'h0});
        n = 0;
        while (!halted && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("p8_rerun", instr_count, 3);

        // NREGS=8: field 9 aliases r1, field 8 aliases r0
        chk("n8_halted", {h8, il8, ov8}, 3'b100);
        chk("n8_alias_r1", st8[0], 32'h55);
        chk("n8_alias_r0", st8[1], 32'h0);
        chk("n8_count", ic8, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle R-type datapath: same MIPS-style ISA subset, executed by a per-instruction state machine.
- Instruction and data memories sit outside the core and are reached through req/ready handshakes, so multi-cycle memories can stall it.
- Adds loads/stores, branches, jumps, a halt, a sticky overflow flag and a retired-instruction counter.
- Intended top-level CPU block of the processor tree.

Parameters:
- XLEN, 32, datapath/register/address width; must be >= 32 (instructions are always 32 bits).
- NREGS, 32, register count, power of two, 2..32. Register index = instruction field modulo NREGS (low log2(NREGS) bits).
- PC_RESET, 0, PC value loaded on reset; word aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch byte address (= PC).
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  data byte address.
- dmem_wdata  out  XLEN  store data.
- dmem_ready  in  1  access complete / load data valid.
- dmem_rdata  in  XLEN  load data.
- halted  out  1  core stopped (HALT state).
- illegal  out  1  halted on an unknown opcode or funct.
- overflow  out  1  sticky signed-overflow flag.
- instr_count  out  32  retired instructions, wraps modulo 2^32.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=PC_RESET, state=FETCH, all outputs 0, registers cleared to 0.
  - Any request in progress is dropped immediately.
  - The first fetch is requested on the first clk edge after rst goes high.
- Register 0 always reads 0; writes to it are discarded.
- FETCH:
  - imem_req=1, imem_addr=PC, both held stable until imem_ready=1.
  - On that edge: IR<=imem_rdata, PC<=PC+4, go to DECODE.
- DECODE: read rs/rt, sign-extend imm[15:0] to XLEN, then go to EXEC.
- EXEC:
  - R-type (opcode 0x00), funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed); rd<=result, retire, go to FETCH.
  - addi (0x08): rt<=rs+simm, retire, go to FETCH.
  - lw (0x23) / sw (0x2B): address = rs+simm, go to MEM.
  - beq (0x04): if rs==rt, PC<=PC+4+(simm<<2); retire, go to FETCH.
  - j (0x02): PC<={PC+4[XLEN-1:28], instr[25:0], 2'b00}; retire, go to FETCH.
  - halt (0x3F): retire, go to HALT.
  - Any other opcode, or an unknown R-type funct: illegal<=1, no retire, go to HALT.
- Writeback: registered at the EXEC edge (R-type, addi) or the MEM completion edge (lw). The result is visible to the next instruction's DECODE.
- MEM:
  - dmem_req=1, with dmem_we/addr/wdata held stable until dmem_ready=1.
  - lw: rt<=dmem_rdata on the ready edge. sw: dmem_wdata=rt.
  - Retire, go to FETCH.
  - Address bits [1:0] are passed through unchecked.
- Latency with ready tied high:
  - R-type, addi, beq, j: 3 cycles.
  - lw, sw: 4 cycles.
  - Each wait cycle in FETCH or MEM adds 1.
- overflow: set when add, sub or addi overflows in signed XLEN arithmetic. The wrapped result is still written. Cleared only by reset.
- instr_count: +1 per retired instruction, on the retiring edge.
- HALT:
  - Terminal; halted=1, no further requests.
  - PC holds the address after the halting instruction.
  - Exit only via reset.
- Req/ready: ready while req=0 is ignored. A request is never withdrawn before ready except by reset.
- Only one of imem_req and dmem_req is high in any cycle.

Test Plan:
- Ready tied 1; program: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; halt -> r3=12, halted=1 at cycle 12, instr_count=4, PC=PC_RESET+16.
- addi r1,r0,0x7FFF then repeated add r1,r1,r1 until overflow -> overflow rises on the add producing 0x7FFF0000 + 0x7FFF0000; stays 1 through halt.
- sw r2,8(r0) with r2=0xDEADBEEF, then lw r4,8(r0); dmem_ready delayed 3 cycles each -> dmem_addr=8, dmem_wdata=0xDEADBEEF held 4 cycles; r4=0xDEADBEEF; each access takes 7 cycles.
- beq r1,r1,-2 after an addi -> PC returns to the addi (loop). With r1!=r2 the branch is not taken and PC=PC+4. j 0x40 -> next imem_addr=0x100.
- Opcode 0x3E -> illegal=1, halted=1, instr_count unchanged. An R-type with funct 0x00 gives the same result.
- Assert rst=0 mid-MEM with dmem_req=1 -> dmem_req drops the same cycle, without waiting for an edge; after release the core fetches from PC_RESET and all outputs are 0. Repeat with NREGS=8: writes to field 9 land in r1.
